// File: rtl/hamming_pkg.sv
// Shared types and constant helpers for the serial cyclic Hamming encoder.
package hamming_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        PARITY = 2'd2
    } state_e;

    localparam int MAX_M = 8;

    // Primitive generator polynomial for each supported parity width, MSB = x^M.
    function automatic logic [MAX_M:0] default_gpoly(input int m);
        case (m)
            3:       default_gpoly = 9'b000001011;
            4:       default_gpoly = 9'b000010011;
            5:       default_gpoly = 9'b000100101;
            6:       default_gpoly = 9'b001000011;
            7:       default_gpoly = 9'b010001001;
            8:       default_gpoly = 9'b100011101;
            default: default_gpoly = 9'b000000000;
        endcase
    endfunction

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/hamming_lfsr.sv
// Remainder register: divides the incoming message stream by the generator polynomial.
module hamming_lfsr
    import hamming_pkg::*;
#(
    parameter int         M     = 3,
    parameter logic [M:0] GPOLY = 4'b1011
) (
    input  logic         clk,
    input  logic         som,
    input  logic         clr,
    input  logic         en,
    input  logic         din,
    output logic [M-1:0] r
);

    logic [M-1:0] r_q;
    logic [M-1:0] r_d;
    logic [M-1:0] base_s;
    logic         fb_s;

    // Clearing folds into the same cycle as the first step so no stale remainder survives.
    always_comb begin
        base_s = clr ? {M{1'b0}} : r_q;
        fb_s   = din ^ base_s[M-1];
        if (en) begin
            r_d = {base_s[M-2:0], 1'b0} ^ (fb_s ? GPOLY[M-1:0] : {M{1'b0}});
        end else begin
            r_d = base_s;
        end
    end

    // Remainder state register.
    always_ff @(posedge clk or posedge som) begin
        if (som) begin
            r_q <= {M{1'b0}};
        end else begin
            r_q <= r_d;
        end
    end

    assign r = r_q;

endmodule

// File: rtl/hamming_serial_enc.sv
// Serial systematic cyclic Hamming (2^M-1, 2^M-1-M) encoder: data bits stream through,
// then the M parity bits, with the full codeword also presented in parallel.
module hamming_serial_enc
    import hamming_pkg::*;
#(
    parameter int         M     = 3,
    parameter logic [M:0] GPOLY = (M+1)'(default_gpoly(M))
) (
    input  logic            clk,
    input  logic            som,
    input  logic            din,
    input  logic            din_valid,
    output logic            din_ready,
    output logic            sout,
    output logic            sout_valid,
    output logic            sout_last,
    output logic [2**M-2:0] cw,
    output logic            cw_valid,
    output logic            busy
);

    localparam int N  = 2**M - 1;
    localparam int K  = N - M;
    localparam int CW = clog2(K + 1);
    localparam logic [CW-1:0] K_LAST = CW'(K - 1);
    localparam logic [CW-1:0] P_LAST = CW'(M - 1);
    localparam logic [CW-1:0] ONE    = CW'(1);

    if (M < 3 || M > MAX_M) begin : g_bad_m
        $error("hamming_serial_enc: M must be in 3..8");
    end
    if (!GPOLY[M] || !GPOLY[0]) begin : g_bad_gpoly
        $error("hamming_serial_enc: GPOLY must have x^M and x^0 terms set");
    end

    state_e          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [K-1:0]    data_q, data_d;
    logic [N-1:0]    cw_q, cw_d;
    logic            sout_q, sout_d;
    logic            sout_valid_q, sout_valid_d;
    logic            sout_last_q, sout_last_d;
    logic            cw_valid_q, cw_valid_d;
    logic            din_ready_q, din_ready_d;
    logic            busy_q, busy_d;
    logic            accept_s;
    logic            lfsr_clr_s;
    logic            lfsr_en_s;
    logic [M-1:0]    r_s;
    logic [M-1:0]    par_shift_s;

    assign accept_s = din_valid && din_ready_q;

    hamming_lfsr #(
        .M     (M),
        .GPOLY (GPOLY)
    ) u_lfsr (
        .clk (clk),
        .som (som),
        .clr (lfsr_clr_s),
        .en  (lfsr_en_s),
        .din (din),
        .r   (r_s)
    );

    // Next-state and output computation; the remainder holds during PARITY and is read MSB first.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        data_d       = data_q;
        cw_d         = cw_q;
        sout_d       = sout_q;
        sout_valid_d = 1'b0;
        sout_last_d  = 1'b0;
        cw_valid_d   = 1'b0;
        lfsr_clr_s   = 1'b0;
        lfsr_en_s    = 1'b0;
        par_shift_s  = r_s << count_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d      = LOAD;
                    count_d      = ONE;
                    lfsr_clr_s   = 1'b1;
                    lfsr_en_s    = 1'b1;
                    data_d       = {data_q[K-2:0], din};
                    sout_d       = din;
                    sout_valid_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                if (accept_s) begin
                    lfsr_en_s    = 1'b1;
                    data_d       = {data_q[K-2:0], din};
                    sout_d       = din;
                    sout_valid_d = 1'b1;
                    if (count_q == K_LAST) begin
                        state_d = PARITY;
                        count_d = {CW{1'b0}};
                    end else begin
                        count_d = count_q + ONE;
                    end
                end else begin
                    state_d = LOAD;
                end
            end
            PARITY: begin
                sout_d       = par_shift_s[M-1];
                sout_valid_d = 1'b1;
                if (count_q == P_LAST) begin
                    sout_last_d = 1'b1;
                    cw_valid_d  = 1'b1;
                    cw_d        = {data_q, r_s};
                    state_d     = IDLE;
                    count_d     = {CW{1'b0}};
                end else begin
                    count_d = count_q + ONE;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = {CW{1'b0}};
            end
        endcase
        din_ready_d = (state_d != PARITY);
        busy_d      = (state_d != IDLE);
    end

    // State and registered outputs; som aborts any message in flight.
    always_ff @(posedge clk or posedge som) begin
        if (som) begin
            state_q      <= IDLE;
            count_q      <= {CW{1'b0}};
            data_q       <= {K{1'b0}};
            cw_q         <= {N{1'b0}};
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            sout_last_q  <= 1'b0;
            cw_valid_q   <= 1'b0;
            din_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            data_q       <= data_d;
            cw_q         <= cw_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            sout_last_q  <= sout_last_d;
            cw_valid_q   <= cw_valid_d;
            din_ready_q  <= din_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign din_ready  = din_ready_q;
    assign sout       = sout_q;
    assign sout_valid = sout_valid_q;
    assign sout_last  = sout_last_q;
    assign cw         = cw_q;
    assign cw_valid   = cw_valid_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_hamming_serial_enc.sv
// Scoreboard bench for hamming_serial_enc: a (7,4) instance for serial/handshake
// behaviour and a (15,11) instance for the wider parametrisation.
module tb_hamming_serial_enc;

    logic        clk;
    logic        som, din, din_valid;
    logic        din_ready, sout, sout_valid, sout_last, cw_valid, busy;
    logic [6:0]  cw;
    logic        som4, din4, dv4;
    logic        dr4, sout4, sv4, sl4, cwv4, busy4;
    logic [14:0] cw4;

    int checks = 0;
    int errors = 0;

    logic [6:0]  exp_cw3[$];
    logic [1:0]  exp_ser3[$];
    logic [14:0] exp_cw4[$];

    hamming_serial_enc #(.M(3), .GPOLY(4'b1011)) dut3 (
        .clk(clk), .som(som), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .sout(sout), .sout_valid(sout_valid), .sout_last(sout_last),
        .cw(cw), .cw_valid(cw_valid), .busy(busy)
    );

    hamming_serial_enc #(.M(4), .GPOLY(5'b10011)) dut4 (
        .clk(clk), .som(som4), .din(din4), .din_valid(dv4), .din_ready(dr4),
        .sout(sout4), .sout_valid(sv4), .sout_last(sl4),
        .cw(cw4), .cw_valid(cwv4), .busy(busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Polynomial long division by x^4+x+1 over a 15-bit vector.
    function automatic logic [3:0] rem4(input logic [14:0] v_in);
        logic [14:0] v;
        logic [14:0] g;
        v = v_in;
        g = 15'b000000000010011;
        for (int i = 14; i >= 4; i--) begin
            if (v[i]) v = v ^ (g << (i - 4));
        end
        return v[3:0];
    endfunction

    // Monitor: pops the scoreboard whenever a DUT presents an output.
    always @(negedge clk) begin
        logic [6:0]  e3;
        logic [1:0]  es;
        logic [14:0] e4;
        if (cw_valid) begin
            chk("last_with_cw", {31'd0, sout_last}, 32'd1);
            if (exp_cw3.size() == 0) begin
                checks++; errors++;
                $display("FAIL cw3_unexpected: got %b expected none", cw);
            end else begin
                e3 = exp_cw3.pop_front();
                chk("cw3", {25'd0, cw}, {25'd0, e3});
            end
        end
        if (sout_valid) begin
            if (exp_ser3.size() == 0) begin
                checks++; errors++;
                $display("FAIL sout3_unexpected: got %b expected none", sout);
            end else begin
                es = exp_ser3.pop_front();
                chk("sout3_bit_last", {30'd0, sout, sout_last}, {30'd0, es});
            end
        end
        if (cwv4) begin
            chk("syndrome4", {28'd0, rem4(cw4)}, 32'd0);
            if (exp_cw4.size() == 0) begin
                checks++; errors++;
                $display("FAIL cw4_unexpected: got %b expected none", cw4);
            end else begin
                e4 = exp_cw4.pop_front();
                chk("cw4", {17'd0, cw4}, {17'd0, e4});
            end
        end
    end

    task automatic wait_ready3();
        int n = 0;
        while (!din_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!din_ready) begin
            checks++; errors++;
            $display("FAIL ready3_timeout: got din_ready 0 expected 1");
        end
    endtask

    task automatic send3(input logic [3:0] msg, input logic [6:0] expc, input logic [3:0] gaps);
        exp_cw3.push_back(expc);
        for (int i = 6; i >= 0; i--) exp_ser3.push_back({expc[i], (i == 0)});
        for (int i = 3; i >= 0; i--) begin
            din = msg[i];
            din_valid = 1'b1;
            wait_ready3();
            @(posedge clk); #1;
            if (gaps[i]) begin
                din_valid = 1'b0;
                @(negedge clk);
                @(negedge clk);
                chk("gap_sout_valid", {31'd0, sout_valid}, 32'd0);
                @(negedge clk);
                chk("gap_sout_valid", {31'd0, sout_valid}, 32'd0);
            end
        end
        din_valid = 1'b0;
    endtask

    task automatic send4(input logic [10:0] msg, input logic [14:0] expc);
        int n;
        exp_cw4.push_back(expc);
        for (int i = 10; i >= 0; i--) begin
            din4 = msg[i];
            dv4 = 1'b1;
            n = 0;
            while (!dr4 && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (!dr4) begin
                checks++; errors++;
                $display("FAIL ready4_timeout: got din_ready 0 expected 1");
            end
            @(posedge clk); #1;
        end
        dv4 = 1'b0;
    endtask

    initial begin
        logic [10:0] m4;
        int n;
        int lows;
        som = 1'b1; som4 = 1'b1;
        din = 1'b0; din_valid = 1'b0;
        din4 = 1'b0; dv4 = 1'b0;
        #2;
        chk("reset_outputs3", {20'd0, din_ready, sout, sout_valid, sout_last, cw, cw_valid, busy}, 32'd0);
        chk("reset_outputs4", {15'd0, dr4, sout4, sv4, sl4, cw4, cwv4, busy4}, 32'd0);
        @(negedge clk);
        som = 1'b0; som4 = 1'b0;
        #1;
        chk("ready_low_before_edge", {31'd0, din_ready}, 32'd0);
        @(posedge clk); #1;
        chk("ready_after_edge", {31'd0, din_ready}, 32'd1);

        // Single message, continuous valid.
        send3(4'b1001, 7'b1001110, 4'b0000);

        // Back-to-back messages with a bubble watcher on sout_valid.
        fork
            begin
                send3(4'b0000, 7'b0000000, 4'b0000);
                send3(4'b1000, 7'b1000101, 4'b0000);
                send3(4'b1111, 7'b1111111, 4'b0000);
            end
            begin
                n = 0;
                @(negedge clk);
                while (!sout_valid && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                lows = 0;
                for (int k = 0; k < 21; k++) begin
                    if (!sout_valid) lows++;
                    if (k < 20) @(negedge clk);
                end
                chk("no_bubble_b2b", lows, 32'd0);
            end
        join

        // Gaps after the first and third bits.
        send3(4'b1001, 7'b1001110, 4'b1010);

        // Valid held during PARITY: no bits taken for three cycles.
        send3(4'b1001, 7'b1001110, 4'b0000);
        din = 1'b1; din_valid = 1'b1;
        chk("parity_ready0", {31'd0, din_ready}, 32'd0);
        @(posedge clk); #1;
        chk("parity_ready1", {31'd0, din_ready}, 32'd0);
        @(posedge clk); #1;
        chk("parity_ready2", {31'd0, din_ready}, 32'd0);
        send3(4'b1111, 7'b1111111, 4'b0000);

        // Abort after two bits; the two emitted data bits are still expected on sout.
        exp_ser3.push_back(2'b10);
        exp_ser3.push_back(2'b00);
        din = 1'b1; din_valid = 1'b1;
        wait_ready3();
        @(posedge clk); #1;
        din = 1'b0;
        wait_ready3();
        @(posedge clk); #1;
        din_valid = 1'b0;
        @(negedge clk); #1;
        som = 1'b1;
        #1;
        chk("som_outputs", {20'd0, din_ready, sout, sout_valid, sout_last, cw, cw_valid, busy}, 32'd0);
        @(posedge clk); #1;
        chk("som_outputs_held", {20'd0, din_ready, sout, sout_valid, sout_last, cw, cw_valid, busy}, 32'd0);
        @(negedge clk);
        som = 1'b0;
        send3(4'b1000, 7'b1000101, 4'b0000);

        // (15,11) directed vector then random messages against the division model.
        send4(11'b10000000000, 15'b100000000001001);
        for (int t = 0; t < 1000; t++) begin
            m4 = 11'($urandom_range(0, 2047));
            send4(m4, {m4, rem4({m4, 4'b0000})});
        end

        n = 0;
        while ((exp_cw3.size() + exp_ser3.size() + exp_cw4.size()) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_empty", exp_cw3.size() + exp_ser3.size() + exp_cw4.size(), 32'd0);
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hamming_serial_enc.md
Name: hamming_serial_enc

Overview:
- Parametrised serial systematic cyclic Hamming (N,K) encoder, successor to the fixed (7,4) serial encoder.
- Accepts K message bits one per cycle under a valid/ready handshake and divides by generator polynomial GPOLY in an LFSR.
- Streams the N-bit codeword serially (data first, then M parity bits) and also presents it in parallel with a one-cycle valid pulse.
- Sits between the serial message source and the channel/serialiser in the ECC datapath.

Parameters:
- M, 3: parity bits; legal range 3..8; N=2**M-1 and K=N-M are derived localparams.
- GPOLY, 4'b1011: generator polynomial, width M+1, MSB = x^M (default x^3+x+1); GPOLY[M] and GPOLY[0] must be 1, else elaboration error.

Ports:
- clk  in  1  clock, all state on rising edge
- som  in  1  asynchronous active-high reset (start of message); clears all state
- din  in  1  serial message bit, first bit = MSB of message
- din_valid  in  1  din qualifier
- din_ready  out  1  encoder can accept a bit; transfer when din_valid && din_ready
- sout  out  1  serial codeword bit
- sout_valid  out  1  sout qualifier, no backpressure
- sout_last  out  1  marks final (N-th) codeword bit
- cw  out  N  parallel codeword {data[K-1:0], parity[M-1:0]}; first received bit at cw[N-1]
- cw_valid  out  1  one-cycle pulse, cw valid
- busy  out  1  high in LOAD (count>0) or PARITY

Behaviour:
- Reset (som high, async): state=IDLE, LFSR r=0, bit count=0, data shift reg=0; sout, sout_valid, sout_last, cw, cw_valid, busy all 0; din_ready 0. din_ready rises at first clk edge after som falls.
- States: IDLE -> LOAD on first accepted bit; LOAD -> PARITY when K-th bit accepted; PARITY -> IDLE after M parity bits emitted.
- din_ready=1 in IDLE/LOAD, 0 in PARITY. Gaps in din_valid during LOAD allowed; r and count hold, sout_valid=0.
- LFSR per accepted bit: fb = din ^ r[M-1]; r <= {r[M-2:0],1'b0} ^ (fb ? GPOLY[M-1:0] : 0). After K bits, r = x^M*d(x) mod g(x).
- Data path: each accepted bit appears on sout with sout_valid=1 one cycle after acceptance (registered).
- PARITY: M consecutive cycles, sout = r[M-1] MSB first, r shifts left, sout_valid=1. If K-th bit accepted at edge e, parity bits appear after edges e+1..e+M; no bubble between last data bit and first parity bit.
- Edge e+M: sout_last=1 and cw_valid=1 for that one cycle; cw = {data, parity}; state -> IDLE. cw holds until the next cw_valid or reset.
- Back-to-back: din_ready re-asserts in the cycle after e+M, so next message's first bit may be accepted the cycle sout_last is high. Throughput = N cycles per codeword.
- Parity register is fully cleared on entry to LOAD; no residue between messages.
- som mid-message: immediate abort, partial message discarded, no cw_valid, no sout_last.
- count width = clog2(K+1); wraps to 0 on LOAD->PARITY.

Decomposition:
- Package hamming_pkg: state enum {IDLE, LOAD, PARITY}; constant function default_gpoly(M) (3:1011, 4:10011, 5:100101, 6:1000011, 7:10001001, 8:100011101); clog2 helper.
- One sub-module: hamming_lfsr (params M, GPOLY; ports clk, som, clr, en, din, r[M-1:0]) holding the remainder register.

Test Plan:
- M=3, msg 1001 continuous valid -> sout 1,0,0,1,1,1,0 on consecutive cycles; cw=7'b1001110; cw_valid and sout_last pulse together on the 7th bit.
- M=3, msgs 0000, 1000, 1111 back-to-back -> cw 0000000, 1000101, 1111111; next message accepted in the sout_last cycle; no idle bubbles on sout.
- M=3, msg 1001 with din_valid low for 2 cycles after bits 1 and 3 -> identical cw 1001110; sout_valid low exactly in the gap cycles.
- din_valid held high during PARITY -> din_ready=0 for 3 cycles; no bits consumed; the next message encodes correctly.
- som pulsed after 2 of 4 bits, then full msg 1000 -> no cw_valid for the aborted message; next cw=1000101; all outputs 0 during som.
- M=4, GPOLY=5'b10011, msg 11'b10000000000 -> parity 1001, cw=15'b100000000001001; random 1000 msgs checked against reference model with syndrome 0.
